// File: rtl/image_mem_pkg.sv
// Shared definitions for the multi-channel image frame RAM.
// Holds the default geometry, the pixel type, the controller state type and a
// small helper used to bound word indices against the implemented depth.
package image_mem_pkg;

    localparam int          DEF_N_CH       = 10;
    localparam int          DEF_DW         = 16;
    localparam int          DEF_AW         = 18;
    localparam int          DEF_ADDR_SHIFT = 2;
    localparam int unsigned DEF_DEPTH      = 153600;

    typedef logic [DEF_DW-1:0] pixel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } img_state_e;

    // Word indices are widened to 32 bits before the compare so the check is
    // independent of the address width the instance was built with.
    function automatic logic word_in_range(input logic [31:0] word_idx,
                                           input int unsigned depth);
        return word_idx < depth;
    endfunction

endpackage

// File: rtl/image_ram_mc_arb_rr_arbiter.sv
// Round-robin arbiter.
// Picks the first asserted request at or after the priority pointer, wrapping
// from N-1 back to 0.
// Ports:
//   req_i        N   request vector
//   ptr_i        IW  index that currently has highest priority (must be < N)
//   grant_o      N   one-hot grant
//   grant_idx_o  IW  index of the granted request
//   any_o        1   at least one request present
module rr_arbiter #(
    parameter int N  = 10,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    int          sum;
    logic [IW-1:0] cand;

    // Walk the requests in priority order starting at the pointer; the first
    // hit wins and later hits are ignored.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        sum         = 0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            sum  = (int'(ptr_i) + k) % N;
            cand = IW'(sum);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/image_ram_mc_arb.sv
// Multi-channel image frame RAM.
// N_CH pixel producers write through valid/ready handshakes into one-entry
// holding registers; a round-robin arbiter drains one entry per cycle into a
// single-write-port RAM. Also provides a registered read port, a frame-clear
// sequencer and a sticky out-of-range flag.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   wr_valid/wr_ready     per-channel write handshake
//   wr_addr/wr_data       packed byte addresses / data, channel i at [i*W +: W]
//   rd_en/rd_addr         read request and byte address
//   rd_data/rd_valid      read result, one cycle after rd_en
//   clr_start             start a frame clear (only honoured when idle)
//   busy                  clear in progress
//   clr_done              one-cycle pulse after the last clear write
//   oor_err               sticky flag for any out-of-range word access
module image_ram_mc_arb
    import image_mem_pkg::*;
#(
    parameter int          N_CH       = DEF_N_CH,
    parameter int          DW         = DEF_DW,
    parameter int          AW         = DEF_AW,
    parameter int          ADDR_SHIFT = DEF_ADDR_SHIFT,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter logic [DW-1:0] CLEAR_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CH-1:0]    wr_valid,
    output logic [N_CH-1:0]    wr_ready,
    input  logic [N_CH*AW-1:0] wr_addr,
    input  logic [N_CH*DW-1:0] wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [DW-1:0]      rd_data,
    output logic               rd_valid,
    input  logic               clr_start,
    output logic               busy,
    output logic               clr_done,
    output logic               oor_err
);

    localparam int WW = AW - ADDR_SHIFT;
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_CH   = IW'(N_CH - 1);
    localparam logic [MW-1:0] LAST_WORD = MW'(DEPTH - 1);

    img_state_e     state_q, state_d;
    logic [MW-1:0]  clr_cnt_q, clr_cnt_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           oor_q, oor_d;
    logic           clr_done_q, clr_done_d;
    logic           rd_valid_q;
    logic [DW-1:0]  rd_data_q;

    logic [WW-1:0]  hold_word_q [N_CH];
    logic [DW-1:0]  hold_data_q [N_CH];

    logic [DW-1:0]  mem [DEPTH];

    logic [N_CH-1:0] ready;
    logic [N_CH-1:0] accept;
    logic [N_CH-1:0] grant_oh;
    logic [IW-1:0]   grant_idx;
    logic            arb_any;
    logic            grant_en;

    logic [31:0]     grant_word;
    logic [31:0]     rd_word;
    logic            grant_in_range;
    logic            rd_in_range;

    logic            ram_we;
    logic [MW-1:0]   ram_widx;
    logic [DW-1:0]   ram_wdata;
    logic            oor_wr;

    logic            unused_addr_lsbs;

    // Ready depends only on registered state, so there is no combinational
    // path from wr_valid to wr_ready.
    assign ready    = ~pending_q & {N_CH{state_q == IDLE}};
    assign wr_ready = ready;
    assign accept   = wr_valid & ready;

    assign busy     = (state_q == CLEAR);
    assign clr_done = clr_done_q;
    assign oor_err  = oor_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // The arbiter only sees registered pending bits, which is what keeps an
    // entry from being granted in the same cycle it is accepted.
    rr_arbiter #(
        .N  (N_CH),
        .IW (IW)
    ) u_arb (
        .req_i       (pending_q),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx),
        .any_o       (arb_any)
    );

    assign grant_en       = (state_q == IDLE) && arb_any;
    assign grant_word     = 32'(hold_word_q[grant_idx]);
    assign grant_in_range = word_in_range(grant_word, DEPTH);
    assign rd_word        = 32'(rd_addr[AW-1:ADDR_SHIFT]);
    assign rd_in_range    = word_in_range(rd_word, DEPTH);

    // The byte-offset bits below ADDR_SHIFT never select anything.
    always_comb begin
        unused_addr_lsbs = ^rd_addr[ADDR_SHIFT-1:0];
        for (int i = 0; i < N_CH; i++) begin
            unused_addr_lsbs = unused_addr_lsbs ^ (^wr_addr[i*AW +: ADDR_SHIFT]);
        end
    end

    // Holding registers only need to capture on acceptance; the pending bit
    // says whether their contents mean anything, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (accept[i]) begin
                hold_word_q[i] <= wr_addr[i*AW + ADDR_SHIFT +: WW];
                hold_data_q[i] <= wr_data[i*DW +: DW];
            end
        end
    end

    // Single RAM write port, shared between the clear sequencer and the
    // arbiter. An out-of-range grant still consumes its slot but only raises
    // the error flag.
    always_comb begin
        ram_we    = 1'b0;
        ram_widx  = '0;
        ram_wdata = '0;
        oor_wr    = 1'b0;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_widx  = clr_cnt_q;
            ram_wdata = CLEAR_VAL;
        end else if (grant_en) begin
            if (grant_in_range) begin
                ram_we    = 1'b1;
                ram_widx  = grant_word[MW-1:0];
                ram_wdata = hold_data_q[grant_idx];
            end else begin
                oor_wr = 1'b1;
            end
        end
    end

    // RAM array has no reset; a clear write issued in the cycle reset is
    // asserted still lands, so an interrupted clear leaves words 0..cnt done.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_widx] <= ram_wdata;
        end
    end

    // Clear sequencer and the rest of the next-state logic. Pending entries
    // sit untouched through a clear and resume from the saved pointer.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == LAST_WORD) begin
                    state_d    = IDLE;
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + MW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = (pending_q & ~(grant_oh & {N_CH{grant_en}})) | accept;

        rr_ptr_d = rr_ptr_q;
        if (grant_en) begin
            rr_ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + IW'(1);
        end

        oor_d = oor_q | oor_wr | (rd_en & ~rd_in_range);
    end

    // Control state and the registered read port. The read samples the array
    // before this edge's write, which gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            oor_q      <= 1'b0;
            clr_done_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            oor_q      <= oor_d;
            clr_done_q <= clr_done_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_in_range ? mem[rd_word[MW-1:0]] : '0;
            end
        end
    end

endmodule

// File: tb/tb_image_ram_mc_arb.sv
// Self-checking bench for image_ram_mc_arb.
// A cycle-level behavioural model predicts handshake/status outputs, and each
// read pushes its expected data into a queue that an independent monitor pops
// whenever rd_valid is seen.
module tb_image_ram_mc_arb;

    localparam int NCH = 10;
    localparam int DW  = 16;
    localparam int AW  = 18;
    localparam int SH  = 2;
    localparam int DEP = 16;
    localparam logic [DW-1:0] CLR = 16'hA5A5;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    wrValid;
    logic [NCH-1:0]    wrReady;
    logic [NCH*AW-1:0] wrAddr;
    logic [NCH*DW-1:0] wrData;
    logic              rdEn;
    logic [AW-1:0]     rdAddr;
    logic [DW-1:0]     rdData;
    logic              rdValid;
    logic              clrStart;
    logic              busy;
    logic              clrDone;
    logic              oorErr;

    // Reference model state
    logic [NCH-1:0] mPend;
    logic [AW-1:0]  mAddr [NCH];
    logic [DW-1:0]  mData [NCH];
    int             mPtr;
    logic [DW-1:0]  mMem  [DEP];
    logic           mBusy;
    int             mCnt;
    logic           mOor;
    logic           mDone;

    logic [DW-1:0]  expQ [$];
    logic [DW-1:0]  monExp;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    image_ram_mc_arb #(
        .N_CH       (NCH),
        .DW         (DW),
        .AW         (AW),
        .ADDR_SHIFT (SH),
        .DEPTH      (DEP),
        .CLEAR_VAL  (CLR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wrValid),
        .wr_ready  (wrReady),
        .wr_addr   (wrAddr),
        .wr_data   (wrData),
        .rd_en     (rdEn),
        .rd_addr   (rdAddr),
        .rd_data   (rdData),
        .rd_valid  (rdValid),
        .clr_start (clrStart),
        .busy      (busy),
        .clr_done  (clrDone),
        .oor_err   (oorErr)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic modelEdge();
        logic [NCH-1:0] readyPre;
        int  widx;
        int  g;
        int  c;
        logic rdOor;
        rdOor = 1'b0;
        for (int i = 0; i < NCH; i++) readyPre[i] = !mPend[i] && !mBusy;

        if (rdEn && !reset) begin
            widx = int'(rdAddr >> SH);
            if (widx < DEP) expQ.push_back(mMem[widx[3:0]]);
            else begin
                expQ.push_back('0);
                rdOor = 1'b1;
            end
        end

        mDone = 1'b0;
        if (mBusy) begin
            mMem[mCnt[3:0]] = CLR;
            if (mCnt == DEP - 1) begin
                mBusy = 1'b0;
                mCnt  = 0;
                mDone = 1'b1;
            end else begin
                mCnt++;
            end
        end else begin
            g = -1;
            for (int k = 0; k < NCH; k++) begin
                c = (mPtr + k) % NCH;
                if (g < 0 && mPend[c]) g = c;
            end
            if (g >= 0) begin
                widx = int'(mAddr[g] >> SH);
                if (widx < DEP) mMem[widx[3:0]] = mData[g];
                else mOor = 1'b1;
                mPend[g] = 1'b0;
                mPtr = (g + 1) % NCH;
            end
            if (clrStart) mBusy = 1'b1;
        end

        for (int i = 0; i < NCH; i++) begin
            if (wrValid[i] && readyPre[i]) begin
                mPend[i] = 1'b1;
                mAddr[i] = wrAddr[i*AW +: AW];
                mData[i] = wrData[i*DW +: DW];
            end
        end
        if (rdOor) mOor = 1'b1;

        if (reset) begin
            mPend = '0;
            mPtr  = 0;
            mBusy = 1'b0;
            mCnt  = 0;
            mOor  = 1'b0;
            mDone = 1'b0;
        end
    endtask

    task automatic checkOutput();
        logic [NCH-1:0] expReady;
        for (int i = 0; i < NCH; i++) expReady[i] = !mPend[i] && !mBusy;
        checkVal("wr_ready", 32'(wrReady), 32'(expReady));
        checkVal("busy",     32'(busy),    32'(mBusy));
        checkVal("clr_done", 32'(clrDone), 32'(mDone));
        checkVal("oor_err",  32'(oorErr),  32'(mOor));
    endtask

    // One clock: inputs already set at the falling edge, checks at the next one.
    task automatic applyStimulus();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic clearInputs();
        reset    = 1'b0;
        wrValid  = '0;
        rdEn     = 1'b0;
        clrStart = 1'b0;
    endtask

    task automatic setWrite(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wrValid[ch]            = 1'b1;
        wrAddr[ch*AW +: AW]    = a;
        wrData[ch*DW +: DW]    = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            clearInputs();
            applyStimulus();
        end
    endtask

    task automatic readAddr(input logic [AW-1:0] a);
        clearInputs();
        rdEn   = 1'b1;
        rdAddr = a;
        applyStimulus();
    endtask

    task automatic readAll();
        for (int w = 0; w < DEP; w++) readAddr(AW'(w * 4));
        idle(1);
    endtask

    // Read-data scoreboard: every read issued must produce exactly one
    // rd_valid on the following edge carrying the predicted word.
    always @(posedge clk) begin
        #1;
        if (rdValid === 1'b1) begin
            if (expQ.size() == 0) begin
                testCount++;
                failCount++;
                $display("[TB] FAIL rd_valid: got 1, expected 0 at %0t", $time);
            end else begin
                monExp = expQ.pop_front();
                checkVal("rd_data", 32'(rdData), 32'(monExp));
            end
        end
        if (expQ.size() != 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL rd_valid: got %0b, expected 1 at %0t", rdValid, $time);
            expQ.delete();
        end
    end

    initial begin
        clearInputs();
        wrAddr = '0;
        wrData = '0;
        rdAddr = '0;
        mPend  = '0;
        mPtr   = 0;
        mBusy  = 1'b0;
        mCnt   = 0;
        mOor   = 1'b0;
        mDone  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            mAddr[i] = '0;
            mData[i] = '0;
        end
        for (int w = 0; w < DEP; w++) mMem[w] = '0;

        @(negedge clk);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        checkVal("reset_rd_valid", 32'(rdValid), 32'd0);
        checkVal("reset_rd_data",  32'(rdData),  32'd0);
        checkVal("reset_wr_ready", 32'(wrReady), 32'h3FF);

        // Frame clear with one write accepted in the start cycle; it must
        // land after the clear and survive.
        clearInputs();
        clrStart = 1'b1;
        setWrite(1, 18'h00014, 16'h5555);
        applyStimulus();
        idle(18);
        readAll();

        // Single write followed by a read-back.
        clearInputs();
        setWrite(3, 18'h00010, 16'hBEEF);
        applyStimulus();
        idle(1);
        readAddr(18'h00010);
        idle(1);

        // Two full bursts on every channel; the second starts after wrap.
        for (int b = 0; b < 2; b++) begin
            clearInputs();
            for (int i = 0; i < NCH; i++) setWrite(i, AW'(i * 4), DW'((b == 0 ? 16'hC000 : 16'hD000) + i));
            applyStimulus();
            idle(11);
        end
        readAll();

        // Same-address conflict with the priority pointer sitting at 5.
        clearInputs();
        setWrite(4, 18'h00030, 16'h4444);
        applyStimulus();
        idle(2);
        clearInputs();
        setWrite(2, 18'h00024, 16'h1111);
        setWrite(7, 18'h00024, 16'h2222);
        applyStimulus();
        idle(3);
        readAddr(18'h00024);
        idle(1);

        // Read of a word written at the same edge sees the old value.
        clearInputs();
        setWrite(0, 18'h00008, 16'h7777);
        applyStimulus();
        readAddr(18'h00008);
        readAddr(18'h00008);
        idle(1);

        // Out-of-range write and read; flag stays up until reset.
        clearInputs();
        setWrite(0, 18'h00040, 16'hDEAD);
        applyStimulus();
        idle(4);
        readAll();
        readAddr(18'h00044);
        idle(3);
        clearInputs();
        reset = 1'b1;
        applyStimulus();
        idle(1);

        // Fill the frame, then interrupt a clear with reset at count 5.
        clearInputs();
        for (int i = 0; i < NCH; i++) setWrite(i, AW'(i * 4), DW'(16'h3000 + i));
        applyStimulus();
        idle(11);
        clearInputs();
        for (int i = 0; i < 6; i++) setWrite(i, AW'((i + 10) * 4), DW'(16'h3000 + i + 10));
        applyStimulus();
        idle(7);
        clearInputs();
        clrStart = 1'b1;
        applyStimulus();
        for (int n = 0; n < 20 && mCnt != 5; n++) begin
            clearInputs();
            applyStimulus();
        end
        clearInputs();
        reset = 1'b1;
        applyStimulus();
        checkVal("reset_mid_clear_busy", 32'(busy), 32'd0);
        checkVal("reset_mid_clear_ready", 32'(wrReady), 32'h3FF);
        idle(1);
        readAll();

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            clearInputs();
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 9) < 3) begin
                    setWrite(i, AW'($urandom_range(0, 17) * 4 + $urandom_range(0, 3)), DW'($urandom));
                end
            end
            rdEn     = ($urandom_range(0, 1) == 1);
            rdAddr   = AW'($urandom_range(0, 17) * 4 + $urandom_range(0, 3));
            clrStart = ($urandom_range(0, 99) < 3);
            applyStimulus();
        end
        idle(40);
        readAll();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
